alu_selftest: RTL and testbench
===============================

# alu_selftest

Sequential exerciser and checker for the 4-bit board ALU.

- Drives every opcode/operand combination onto the ALU's `btn`/`sw1`/`sw2` inputs and waits a programmable settle time.
- Compares the ALU's 7-bit `ld` output against an internal golden model.
- Reports pass/fail, a saturating error count and the first failing vector.
- Sits between the board-level ALU instance and the status LEDs/segment display, as the stimulus/response end of the ALU's switch/LED interface.

## Interface
Parameters:
- `SETTLE`, default 1 — cycles waited after driving a vector before sampling `ld` (1..15).

Ports:
- `clk`  in  1  — single clock.
- `rst`  in  1  — reset, asynchronous, active-high.
- `start`  in  1  — one-cycle pulse; begins a run from IDLE or DONE.
- `btn`  out  3  — opcode to ALU, registered.
- `sw1`  out  4  — operand A to ALU, registered.
- `sw2`  out  4  — operand B to ALU, registered.
- `ld`  in  7  — ALU result/flags.
- `busy`  out  1  — high while a run is in progress.
- `done`  out  1  — high in DONE.
- `pass`  out  1  — in DONE, high iff `err_count == 0`; 0 otherwise.
- `err_count`  out  8  — mismatches, saturating at 255.
- `fail_idx`  out  11  — index of the first mismatching vector.
- `fail_ld`  out  7  — `ld` value at the first mismatch.

## Operation
- Vector index `idx[10:0]`; the outputs are `btn = idx[10:8]`, `sw1 = idx[7:4]`, `sw2 = idx[3:0]`. A run covers 2048 vectors, 0 → 2047.
- Golden model (`a = sw1`, `b = sw2`):
  - **op 0, add:** ripple sum `s[3:0]`. `exp[3:0] = s`, `[4] = carry out`, `[5] = c3 ^ c4`, `[6] = ~|s[2:0]` (low three bits only).
  - **op 1, sub:** `b' = {1'b1, (~b + 1)[2:0]}`, then apply the op 0 rule to `(a, b')`.
  - **op 2:** `{3'b0, ~a}`.
  - **op 3:** `{3'b0, a & b}`.
  - **op 4:** `{3'b0, a | b}`.
  - **op 5:** `{3'b0, a ^ b}`.
  - **op 6, compare:** unsigned compare of `a[2:0]` and `b[2:0]`. `[6:4] = {3{gt}}`, `[3] = eq`, `[2:0] = {3{lt}}`.
  - **op 7, eq:** `{7{a[2:0] == b[2:0]}}`.
- FSM states:
  - **IDLE:** on `start`, go to DRIVE with `idx = 0`, `err_count = 0`, `fail_*` cleared.
  - **DRIVE:** register `btn`/`sw1`/`sw2` from `idx`; go to WAIT.
  - **WAIT:** count SETTLE cycles; go to CHECK.
  - **CHECK:** compare `ld` with the golden model of the currently driven vector.
    - On mismatch: `err_count` increments, saturating at 255. `fail_idx`/`fail_ld` are written only on the first mismatch.
    - If `idx == 2047`, go to DONE. Otherwise `idx++` and go to DRIVE.
  - **DONE:** `done = 1`, `pass` valid, `btn`/`sw1`/`sw2` hold the last vector. `start` restarts exactly as from IDLE.
- `busy = 1` in DRIVE, WAIT and CHECK.
- `start` while busy is ignored.
- Reset values (all outputs): `btn = 0`, `sw1 = 0`, `sw2 = 0`, `busy = 0`, `done = 0`, `pass = 0`, `err_count = 0`, `fail_idx = 0`, `fail_ld = 0`; FSM in IDLE.
- Reset mid-run aborts immediately to these values. No partial result is retained.

## Timing
- Each vector takes `2 + SETTLE` cycles: DRIVE, SETTLE × WAIT, CHECK.
- `busy` rises the cycle after `start` is sampled.
- `done` rises `2048 × (2 + SETTLE)` cycles after `busy` rises. With SETTLE = 1 this is 6144 cycles.
- `ld` is sampled combinationally in CHECK. The ALU is combinational, so `ld` reflects the vector registered in DRIVE.
- `err_count`, `fail_idx` and `fail_ld` update on the clock edge ending CHECK.
- In DONE, `pass` is valid in the same cycle that `done` is high.

## Structure
- Shared package `alu_pkg`:
  - opcode constants `OP_ADD` = 0 … `OP_EQ` = 7;
  - FSM state enum;
  - `NUM_VEC` = 2048;
  - result width 7, operand width 4.
- Sub-module `alu_golden`: combinational model, `(op, a, b) → exp[6:0]`.
  - Kept separate so the testbench can reuse it as its scoreboard.
- Top contains the FSM, index counter, settle counter and error logging.

## Test plan
- **Correct ALU model attached, SETTLE = 1:** `start` → `done` after 6144 cycles, `pass = 1`, `err_count = 0`.
- **Golden spot check:** op 0, `a = 7`, `b = 1` → `exp = 7'h68`. Checker accepts `ld = 7'h68` and flags `ld = 7'h48`.
- **Fault injection, `ld` forced to 0 when `btn == 7`:** `err_count = 32`, `fail_idx = 11'h700`, `fail_ld = 0`, `pass = 0`.
- **`ld` stuck at 0 for all ops:** mismatch at `idx = 0` (expected `7'h40`), so `fail_idx = 0`; `err_count` saturates at 255 and `pass = 0`.
- **Reset mid-run:** assert `rst` at cycle 1000 of a run → all outputs return to reset values the same cycle. A subsequent `start` completes normally with `pass = 1`.
- **Control handling:** `start` pulsed while busy leaves `idx` and the error state undisturbed. `start` in DONE reruns with counters cleared. SETTLE = 3 gives a run of 10240 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants, opcode encodings and FSM state type for
//                the 4-bit board ALU exerciser.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int OPND_W  = 4;      // operand width (sw1/sw2)
    localparam int RES_W   = 7;      // ALU result/flag width (ld)
    localparam int OP_W    = 3;      // opcode width (btn)
    localparam int IDX_W   = OP_W + 2 * OPND_W;
    localparam int NUM_VEC = 2048;   // every opcode/operand combination

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_NOT = 3'd2;
    localparam logic [OP_W-1:0] OP_AND = 3'd3;
    localparam logic [OP_W-1:0] OP_OR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR = 3'd5;
    localparam logic [OP_W-1:0] OP_CMP = 3'd6;
    localparam logic [OP_W-1:0] OP_EQ  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_selftest_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_selftest_if
//  Description : Switch/LED bus between the exerciser (master) and the ALU
//                under test (slave): opcode and operands out, result back.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_selftest_if;

    logic [alu_pkg::OP_W-1:0]   btn;
    logic [alu_pkg::OPND_W-1:0] sw1;
    logic [alu_pkg::OPND_W-1:0] sw2;
    logic [alu_pkg::RES_W-1:0]  ld;

    modport master (output btn, output sw1, output sw2, input ld);
    modport slave  (input btn, input sw1, input sw2, output ld);

endinterface : alu_selftest_if
`default_nettype wire

// File: rtl/alu_golden.sv
`default_nettype none
// ============================================================================
//  Module      : alu_golden
//  Description : Combinational reference model of the board ALU,
//                (op, a, b) -> expected ld value.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_golden
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [RES_W-1:0]  exp
);

    // Ripple adder with the board's flag packing: zero looks only at s[2:0],
    // overflow is carry-into-msb xor carry-out.
    function automatic logic [RES_W-1:0] add_flags(input logic [OPND_W-1:0] x,
                                                   input logic [OPND_W-1:0] y);
        logic [OPND_W:0]   c;
        logic [OPND_W-1:0] s;
        c[0] = 1'b0;
        for (int i = 0; i < OPND_W; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        return {~|s[2:0], c[3] ^ c[4], c[4], s};
    endfunction

    logic [OPND_W-1:0] w_bneg;
    logic [OPND_W-1:0] w_bsub;
    logic              w_lt;
    logic              w_gt;
    logic              w_eq;

    assign w_bneg = ~b + 4'd1;
    // The board's subtractor forces the msb of the negated operand high.
    assign w_bsub = {1'b1, w_bneg[2:0]};
    assign w_lt   = a[2:0] <  b[2:0];
    assign w_gt   = a[2:0] >  b[2:0];
    assign w_eq   = a[2:0] == b[2:0];

    // Opcode decode to the expected result/flag word.
    always_comb begin
        exp = '0;
        case (op)
            OP_ADD:  exp = add_flags(a, b);
            OP_SUB:  exp = add_flags(a, w_bsub);
            OP_NOT:  exp = {3'b000, ~a};
            OP_AND:  exp = {3'b000, a & b};
            OP_OR:   exp = {3'b000, a | b};
            OP_XOR:  exp = {3'b000, a ^ b};
            OP_CMP:  exp = {{3{w_gt}}, w_eq, {3{w_lt}}};
            OP_EQ:   exp = {7{w_eq}};
            default: exp = '0;
        endcase
    end

endmodule : alu_golden
`default_nettype wire

// File: rtl/alu_selftest.sv
`default_nettype none
// ============================================================================
//  Module      : alu_selftest
//  Description : Walks all 2048 opcode/operand vectors through the board ALU,
//                compares ld against the golden model and logs errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_selftest
    import alu_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    alu_selftest_if.master    bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [RES_W-1:0]  fail_ld
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_VEC - 1);
    localparam logic [3:0]       c_settle_m1 = 4'(SETTLE - 1);

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [3:0]         r_settle;
    logic [OP_W-1:0]    r_btn;
    logic [OPND_W-1:0]  r_sw1;
    logic [OPND_W-1:0]  r_sw2;
    logic [7:0]         r_err;
    logic [IDX_W-1:0]   r_fail_idx;
    logic [RES_W-1:0]   r_fail_ld;
    logic [RES_W-1:0]   w_exp;
    logic               w_miss;

    // Reference is fed from the registered vector, i.e. what the ALU sees.
    alu_golden u_golden (
        .op  (r_btn),
        .a   (r_sw1),
        .b   (r_sw2),
        .exp (w_exp)
    );

    assign w_miss    = (bus.ld != w_exp);
    assign bus.btn   = r_btn;
    assign bus.sw1   = r_sw1;
    assign bus.sw2   = r_sw2;
    assign err_count = r_err;
    assign fail_idx  = r_fail_idx;
    assign fail_ld   = r_fail_ld;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode and status outputs.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        pass   = 1'b0;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_DRIVE;
            ST_DRIVE: begin
                busy   = 1'b1;
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (r_settle == c_settle_m1) w_next = ST_CHECK;
            end
            ST_CHECK: begin
                busy   = 1'b1;
                w_next = (r_idx == c_last_idx) ? ST_DONE : ST_DRIVE;
            end
            ST_DONE: begin
                done = 1'b1;
                pass = (r_err == 8'd0);
                if (start) w_next = ST_DRIVE;
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    // Vector index, ALU drive, settle counter and error logging. The first
    // mismatch is recognised by the error count still being zero, which is
    // safe because the count saturates instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_settle   <= '0;
            r_btn      <= '0;
            r_sw1      <= '0;
            r_sw2      <= '0;
            r_err      <= '0;
            r_fail_idx <= '0;
            r_fail_ld  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_idx      <= '0;
                        r_err      <= '0;
                        r_fail_idx <= '0;
                        r_fail_ld  <= '0;
                    end
                end
                ST_DRIVE: begin
                    r_btn    <= r_idx[10:8];
                    r_sw1    <= r_idx[7:4];
                    r_sw2    <= r_idx[3:0];
                    r_settle <= '0;
                end
                ST_WAIT: r_settle <= r_settle + 4'd1;
                ST_CHECK: begin
                    if (w_miss) begin
                        if (r_err != 8'hFF) r_err <= r_err + 8'd1;
                        if (r_err == 8'd0) begin
                            r_fail_idx <= r_idx;
                            r_fail_ld  <= bus.ld;
                        end
                    end
                    if (r_idx != c_last_idx) r_idx <= r_idx + 11'd1;
                end
                default: ;
            endcase
        end
    end

endmodule : alu_selftest
`default_nettype wire

// File: tb/tb_alu_selftest.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_selftest
//  Description : Directed bench for alu_selftest with a behavioural board ALU
//                whose fault mode can be switched between runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_selftest;

    logic        clk;
    logic        rst;
    logic        r_start;
    logic        r_start3;
    int          r_mode;       // 0 good, 1 spot fault, 2 op7 -> 0, 3 stuck 0
    int          n_vec;
    int          n_miscompare;

    logic        busy, done, pass;
    logic [7:0]  err_count;
    logic [10:0] fail_idx;
    logic [6:0]  fail_ld;
    logic        busy3, done3, pass3;
    logic [7:0]  err_count3;
    logic [10:0] fail_idx3;
    logic [6:0]  fail_ld3;

    logic [2:0]  g_op;
    logic [3:0]  g_a, g_b;
    logic [6:0]  g_exp;

    alu_selftest_if u_bus1 ();
    alu_selftest_if u_bus3 ();

    alu_selftest #(.SETTLE(1)) u_dut (
        .clk(clk), .rst(rst), .start(r_start), .bus(u_bus1),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_idx(fail_idx), .fail_ld(fail_ld)
    );

    alu_selftest #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(r_start3), .bus(u_bus3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3),
        .fail_idx(fail_idx3), .fail_ld(fail_ld3)
    );

    alu_golden u_gold (.op(g_op), .a(g_a), .b(g_b), .exp(g_exp));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board ALU written arithmetically, independent of the gate-level model.
    function automatic logic [6:0] tb_add(input int x, input int y);
        int sum, s, c4, c3, z;
        sum = x + y;
        s   = sum % 16;
        c4  = sum / 16;
        c3  = ((x % 8) + (y % 8)) / 8;
        z   = ((s % 8) == 0) ? 1 : 0;
        return 7'(z * 64 + (c3 ^ c4) * 32 + c4 * 16 + s);
    endfunction

    function automatic logic [6:0] tb_alu(input int mode, input logic [2:0] op,
                                          input logic [3:0] a, input logic [3:0] b);
        int ia, ib, la, lb;
        logic [6:0] r;
        ia = int'(a); ib = int'(b); la = ia % 8; lb = ib % 8;
        case (op)
            3'd0: r = tb_add(ia, ib);
            3'd1: r = tb_add(ia, 8 + ((16 - ib) % 8));
            3'd2: r = 7'(15 - ia);
            3'd3: r = {3'b000, a & b};
            3'd4: r = {3'b000, a | b};
            3'd5: r = {3'b000, a ^ b};
            3'd6: r = (la > lb) ? 7'h70 : ((la == lb) ? 7'h08 : 7'h07);
            default: r = (la == lb) ? 7'h7F : 7'h00;
        endcase
        if (mode == 1 && op == 3'd0 && a == 4'd7 && b == 4'd1) r = 7'h48;
        if (mode == 2 && op == 3'd7) r = 7'h00;
        if (mode == 3) r = 7'h00;
        return r;
    endfunction

    assign u_bus1.ld = tb_alu(r_mode, u_bus1.btn, u_bus1.sw1, u_bus1.sw2);
    assign u_bus3.ld = tb_alu(0, u_bus3.btn, u_bus3.sw1, u_bus3.sw2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_miscompare++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_btn"}, 32'(u_bus1.btn), 32'd0);
        chk({tag, "_sw"},  32'({u_bus1.sw1, u_bus1.sw2}), 32'd0);
        chk({tag, "_stat"}, 32'({busy, done, pass}), 32'd0);
        chk({tag, "_err"}, 32'(err_count), 32'd0);
        chk({tag, "_fidx"}, 32'(fail_idx), 32'd0);
        chk({tag, "_fld"}, 32'(fail_ld), 32'd0);
    endtask

    // Start a run on the SETTLE=1 instance and count cycles from busy rising
    // to done; optionally pulse start mid-run or abort with reset.
    task automatic run1(input string tag, input int pulse_at, input int abort_at,
                        output int cyc);
        int n;
        @(negedge clk);
        r_start = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
        n = 0;
        while (1) begin
            @(negedge clk);
            r_start = (pulse_at > 0 && n == pulse_at) ? 1'b1 : 1'b0;
            @(posedge clk);
            n++;
            #1;
            if (abort_at > 0 && n == abort_at) begin
                rst = 1'b1;
                #1;
                chk_reset_vals({tag, "_abort"});
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            if (done) break;
            if (n >= 20000) begin
                chk({tag, "_timeout"}, 32'(done), 32'd1);
                break;
            end
        end
        r_start = 1'b0;
        cyc = n;
    endtask

    initial begin
        int cyc;
        n_vec = 0;
        n_miscompare = 0;
        r_mode = 0;
        r_start = 1'b0;
        r_start3 = 1'b0;
        rst = 1'b1;
        g_op = 3'd0; g_a = 4'd0; g_b = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_vals("reset");

        // Golden model spot values.
        g_op = 3'd0; g_a = 4'd7; g_b = 4'd1; #1;
        chk("gold_add_7_1", 32'(g_exp), 32'h68);
        g_op = 3'd0; g_a = 4'd0; g_b = 4'd0; #1;
        chk("gold_add_0_0", 32'(g_exp), 32'h40);
        g_op = 3'd1; g_a = 4'd5; g_b = 4'd3; #1;
        chk("gold_sub_5_3", 32'(g_exp), 32'h12);
        g_op = 3'd6; g_a = 4'd5; g_b = 4'd3; #1;
        chk("gold_cmp_gt", 32'(g_exp), 32'h70);
        g_op = 3'd6; g_a = 4'd8; g_b = 4'd0; #1;
        chk("gold_cmp_eq_msb", 32'(g_exp), 32'h08);
        g_op = 3'd7; g_a = 4'd9; g_b = 4'd2; #1;
        chk("gold_eq_ne", 32'(g_exp), 32'h00);

        // Good ALU, full run.
        r_mode = 0;
        run1("good", 0, 0, cyc);
        chk("good_cycles", 32'(cyc), 32'd6144);
        chk("good_pass", 32'(pass), 32'd1);
        chk("good_err", 32'(err_count), 32'd0);
        chk("good_busy", 32'(busy), 32'd0);
        chk("good_last_vec", 32'({u_bus1.btn, u_bus1.sw1, u_bus1.sw2}), 32'h7FF);

        // Single bad vector: op0 a=7 b=1 returns 0x48 instead of 0x68.
        r_mode = 1;
        run1("spot", 0, 0, cyc);
        chk("spot_err", 32'(err_count), 32'd1);
        chk("spot_fidx", 32'(fail_idx), 32'h071);
        chk("spot_fld", 32'(fail_ld), 32'h48);
        chk("spot_pass", 32'(pass), 32'd0);

        // op7 forced to 0, with a stray start pulse mid-run.
        r_mode = 2;
        run1("op7", 3000, 0, cyc);
        chk("op7_cycles", 32'(cyc), 32'd6144);
        chk("op7_err", 32'(err_count), 32'd32);
        chk("op7_fidx", 32'(fail_idx), 32'h700);
        chk("op7_fld", 32'(fail_ld), 32'h00);
        chk("op7_pass", 32'(pass), 32'd0);

        // ld stuck at zero: error count saturates.
        r_mode = 3;
        run1("stuck", 0, 0, cyc);
        chk("stuck_err", 32'(err_count), 32'd255);
        chk("stuck_fidx", 32'(fail_idx), 32'h000);
        chk("stuck_fld", 32'(fail_ld), 32'h00);
        chk("stuck_pass", 32'(pass), 32'd0);
        chk("stuck_done", 32'(done), 32'd1);

        // Restart from DONE clears the log.
        r_mode = 0;
        @(negedge clk);
        r_start = 1'b1;
        @(posedge clk);
        #1;
        r_start = 1'b0;
        chk("restart_err_clr", 32'(err_count), 32'd0);
        chk("restart_done_low", 32'(done), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run1("rerun", 0, 0, cyc);
        chk("rerun_pass", 32'(pass), 32'd1);
        chk("rerun_cycles", 32'(cyc), 32'd6144);

        // Reset mid-run, after some errors have been logged.
        r_mode = 3;
        run1("abort", 0, 1000, cyc);
        r_mode = 0;
        run1("post_abort", 0, 0, cyc);
        chk("post_abort_pass", 32'(pass), 32'd1);
        chk("post_abort_err", 32'(err_count), 32'd0);

        // SETTLE=3 instance.
        begin
            int n;
            @(negedge clk);
            r_start3 = 1'b1;
            @(posedge clk);
            #1;
            chk("s3_busy_rise", 32'(busy3), 32'd1);
            @(negedge clk);
            r_start3 = 1'b0;
            n = 0;
            while (1) begin
                @(posedge clk);
                n++;
                #1;
                if (done3) break;
                if (n >= 20000) begin
                    chk("s3_timeout", 32'(done3), 32'd1);
                    break;
                end
            end
            chk("s3_cycles", 32'(n), 32'd10240);
            chk("s3_pass", 32'(pass3), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule : tb_alu_selftest
`default_nettype wire
